// File: rtl/txpll_pkg.sv
// Shared types and constants for the TX PLL lock supervisor.
package txpll_pkg;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_FILTER,
    ST_LOCKED,
    ST_RESTART
  } chan_state_e;

  localparam int                    LOSS_CNT_W   = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  // Clear wins over the held value but still admits the coincident loss.
  function automatic logic [LOSS_CNT_W-1:0] loss_cnt_next(
    input logic [LOSS_CNT_W-1:0] cur,
    input logic                  clr,
    input logic                  inc
  );
    if (clr) return inc ? LOSS_CNT_W'(1) : '0;
    if (inc && cur != LOSS_CNT_MAX) return cur + 1'b1;
    return cur;
  endfunction

endpackage

// File: rtl/txpll_lock_chan.sv
// One supervised TX PLL: lock synchronizer, WAIT/FILTER/LOCKED/RESTART FSM and registered outputs.
// The loss counter exists only when TXPLL_LOSS_COUNTER_EN is defined; otherwise loss_cnt is tied to 0.
module txpll_lock_chan
  import txpll_pkg::*;
#(
  parameter int LOCK_FILT   = 256,
  parameter int TIMEOUT_CYC = 65536,
  parameter int RESTART_CYC = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock,
  input  logic                  force_restart,
  input  logic                  clr_cnt,
  output logic                  pll_restart,
  output logic                  locked,
  output logic                  loss_evt,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int TMR_W  = $clog2(TIMEOUT_CYC);
  localparam int FILT_W = $clog2(LOCK_FILT);
  localparam int RCNT_W = 8;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESTART_CYC - 1);

  logic [1:0]        sync;
  logic              lock_s;
  chan_state_e       state;
  chan_state_e       state_nxt;
  logic [TMR_W-1:0]  timer;
  logic [FILT_W-1:0] filt;
  logic [RCNT_W-1:0] rcnt;
  logic              restart_d;
  logic              locked_d;
  logic              loss_d;

  // NOTE: non-blocking assignments let the two flops shift as a pipeline instead of collapsing into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], pll_lock};
  end

  assign lock_s = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WAIT;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (force_restart) begin
      state_nxt = ST_RESTART;
    end else begin
      unique case (state)
        ST_WAIT:    if (lock_s)               state_nxt = ST_FILTER;
                    else if (timer == TMR_LAST) state_nxt = ST_RESTART;
        ST_FILTER:  if (!lock_s)              state_nxt = ST_WAIT;
                    else if (filt == FILT_LAST) state_nxt = ST_LOCKED;
        ST_LOCKED:  if (!lock_s)              state_nxt = ST_WAIT;
        ST_RESTART: if (rcnt == RCNT_LAST)    state_nxt = ST_WAIT;
        default:                              state_nxt = ST_WAIT;
      endcase
    end
  end

  // Every counter restarts on entry to its state; a re-forced restart rewinds the pulse width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
      filt  <= '0;
      rcnt  <= '0;
    end else begin
      timer <= (state == ST_WAIT && state_nxt == ST_WAIT) ? timer + 1'b1 : '0;
      filt  <= (state_nxt != ST_FILTER) ? '0 :
               (state == ST_FILTER)     ? filt + 1'b1 : FILT_W'(1);
      rcnt  <= (state == ST_RESTART && state_nxt == ST_RESTART && !force_restart) ?
               rcnt + 1'b1 : '0;
    end
  end

  always_comb begin
    restart_d = (state_nxt == ST_RESTART);
    locked_d  = (state_nxt == ST_LOCKED);
    loss_d    = (state == ST_LOCKED) && (state_nxt == ST_WAIT);
  end

  // Outputs are registered alongside the state so they track it cycle for cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pll_restart <= 1'b0;
      locked      <= 1'b0;
      loss_evt    <= 1'b0;
    end else begin
      pll_restart <= restart_d;
      locked      <= locked_d;
      loss_evt    <= loss_d;
    end
  end

`ifdef TXPLL_LOSS_COUNTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) loss_cnt <= '0;
    else     loss_cnt <= loss_cnt_next(loss_cnt, clr_cnt, loss_d);
  end
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign loss_cnt       = '0;
`endif

endmodule

// File: rtl/txpll_lock_supervisor.sv
// Supervises N_PLL TX PLLs: one txpll_lock_chan per PLL plus the registered ALL_LOCKED summary.
// Define TXPLL_LOSS_COUNTER_EN to build the per-channel loss counters behind LOSS_CNT/CLR_CNT.
module txpll_lock_supervisor
  import txpll_pkg::*;
#(
  parameter int N_PLL       = 2,
  parameter int LOCK_FILT   = 256,
  parameter int TIMEOUT_CYC = 65536,
  parameter int RESTART_CYC = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [N_PLL-1:0]              PLL_LOCK,
  input  logic [N_PLL-1:0]              FORCE_RESTART,
  input  logic                          CLR_CNT,
  output logic [N_PLL-1:0]              PLL_RESTART,
  output logic [N_PLL-1:0]              LOCKED,
  output logic                          ALL_LOCKED,
  output logic [N_PLL-1:0]              LOSS_EVT,
  output logic [LOSS_CNT_W*N_PLL-1:0]   LOSS_CNT
);

  for (genvar i = 0; i < N_PLL; i++) begin : g_chan
    txpll_lock_chan #(
      .LOCK_FILT   (LOCK_FILT),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .RESTART_CYC (RESTART_CYC)
    ) u_chan (
      .clk           (CLK),
      .rst           (RST),
      .pll_lock      (PLL_LOCK[i]),
      .force_restart (FORCE_RESTART[i]),
      .clr_cnt       (CLR_CNT),
      .pll_restart   (PLL_RESTART[i]),
      .locked        (LOCKED[i]),
      .loss_evt      (LOSS_EVT[i]),
      .loss_cnt      (LOSS_CNT[LOSS_CNT_W*i +: LOSS_CNT_W])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ALL_LOCKED <= 1'b0;
    else     ALL_LOCKED <= &LOCKED;
  end

endmodule

// File: tb/tb_txpll_lock_supervisor.sv
// Self-checking bench for txpll_lock_supervisor: directed scenarios then random traffic, all compared
// every cycle against a run-length/countdown reference model. Honours TXPLL_LOSS_COUNTER_EN.
module tb_txpll_lock_supervisor;

  localparam int N_PLL       = 2;
  localparam int LOCK_FILT   = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int RESTART_CYC = 3;
`ifdef TXPLL_LOSS_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [N_PLL-1:0]     PLL_LOCK;
  logic [N_PLL-1:0]     FORCE_RESTART;
  logic                 CLR_CNT;
  logic [N_PLL-1:0]     PLL_RESTART;
  logic [N_PLL-1:0]     LOCKED;
  logic                 ALL_LOCKED;
  logic [N_PLL-1:0]     LOSS_EVT;
  logic [8*N_PLL-1:0]   LOSS_CNT;

  always #5 CLK = ~CLK;

  txpll_lock_supervisor #(
    .N_PLL       (N_PLL),
    .LOCK_FILT   (LOCK_FILT),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .RESTART_CYC (RESTART_CYC)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .PLL_LOCK      (PLL_LOCK),
    .FORCE_RESTART (FORCE_RESTART),
    .CLR_CNT       (CLR_CNT),
    .PLL_RESTART   (PLL_RESTART),
    .LOCKED        (LOCKED),
    .ALL_LOCKED    (ALL_LOCKED),
    .LOSS_EVT      (LOSS_EVT),
    .LOSS_CNT      (LOSS_CNT)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: restart as a countdown, filtering as a run length of synced-high cycles,
  // waiting as an age since the channel last entered wait.
  bit m_s1[N_PLL], m_s2[N_PLL], m_locked[N_PLL], m_evt[N_PLL];
  int m_restart_left[N_PLL], m_run[N_PLL], m_age[N_PLL], m_cnt[N_PLL];
  bit m_all;

  function automatic void model_reset();
    m_all = 1'b0;
    for (int i = 0; i < N_PLL; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_locked[i] = 0; m_evt[i] = 0;
      m_restart_left[i] = 0; m_run[i] = 0; m_age[i] = 0; m_cnt[i] = 0;
    end
  endfunction

  function automatic void model_step();
    bit all = 1'b1;
    for (int i = 0; i < N_PLL; i++) all &= m_locked[i];
    m_all = all;
    for (int i = 0; i < N_PLL; i++) begin
      bit s = m_s2[i];
      m_evt[i] = 0;
      if (FORCE_RESTART[i]) begin
        m_restart_left[i] = RESTART_CYC; m_locked[i] = 0; m_run[i] = 0; m_age[i] = 0;
      end else if (m_restart_left[i] > 0) begin
        m_restart_left[i]--; m_age[i] = 0;
      end else if (m_locked[i]) begin
        if (!s) begin m_locked[i] = 0; m_evt[i] = 1; m_age[i] = 0; end
      end else if (m_run[i] > 0) begin
        if (!s) begin
          m_run[i] = 0; m_age[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == LOCK_FILT) begin m_locked[i] = 1; m_run[i] = 0; end
        end
      end else if (s) begin
        m_run[i] = 1;
      end else if (m_age[i] == TIMEOUT_CYC - 1) begin
        m_restart_left[i] = RESTART_CYC; m_age[i] = 0;
      end else begin
        m_age[i]++;
      end
      if (CLR_CNT)                       m_cnt[i] = m_evt[i] ? 1 : 0;
      else if (m_evt[i] && m_cnt[i] < 255) m_cnt[i]++;
      m_s2[i] = m_s1[i];
      m_s1[i] = PLL_LOCK[i];
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [N_PLL-1:0]   e_rst, e_lk, e_evt;
    logic [8*N_PLL-1:0] e_cnt;
    for (int i = 0; i < N_PLL; i++) begin
      e_rst[i]       = (m_restart_left[i] > 0);
      e_lk[i]        = m_locked[i];
      e_evt[i]       = m_evt[i];
      e_cnt[8*i +: 8] = CNT_EN ? 8'(m_cnt[i]) : 8'd0;
    end
    check({tag, ".pll_restart"}, 32'(PLL_RESTART), 32'(e_rst));
    check({tag, ".locked"},      32'(LOCKED),      32'(e_lk));
    check({tag, ".all_locked"},  32'(ALL_LOCKED),  32'(m_all));
    check({tag, ".loss_evt"},    32'(LOSS_EVT),    32'(e_evt));
    check({tag, ".loss_cnt"},    32'(LOSS_CNT),    32'(e_cnt));
  endtask

  // One clock: model advances on the edge, DUT outputs are sampled 1 unit later.
  task automatic cycle(input string tag);
    @(posedge CLK);
    if (RST) model_reset();
    else     model_step();
    #1 compare_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no $finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_lk0, first_lk1, first_all, fall, relock, evts, width, w, prev;
    int rises[$];
    int widths[$];

    RST = 1'b1; PLL_LOCK = '0; FORCE_RESTART = '0; CLR_CNT = 1'b0;
    model_reset();
    #2 compare_all("reset");
    cycle("reset_hold");
    cycle("reset_hold");
    RST = 1'b0;

    // Lock channel 0, then channel 1; ALL_LOCKED must trail LOCKED[1] by one cycle.
    PLL_LOCK[0] = 1'b1;
    first_lk0 = -1;
    for (int k = 0; k < 12; k++) begin
      cycle("lock0");
      if (LOCKED[0] && first_lk0 < 0) first_lk0 = k;
    end
    check("lock0_rise_edge", first_lk0, LOCK_FILT + 1);
    check("all_locked_while_ch1_down", ALL_LOCKED, 0);

    PLL_LOCK[1] = 1'b1;
    first_lk1 = -1; first_all = -1;
    for (int k = 0; k < 40; k++) begin
      cycle("lock1");
      if (LOCKED[1] && first_lk1 < 0) first_lk1 = k;
      if (ALL_LOCKED && first_all < 0) first_all = k;
    end
    check("lock1_seen", first_lk1 >= 0, 1);
    check("all_locked_lag", first_all, first_lk1 + 1);

    // Single-cycle dropout on a locked channel.
    fall = -1; relock = -1; evts = 0;
    for (int k = 0; k < 12; k++) begin
      PLL_LOCK[0] = (k != 0);
      cycle("loss1");
      evts += int'(LOSS_EVT[0]);
      if (!LOCKED[0] && fall < 0) fall = k;
      if (LOCKED[0] && fall >= 0 && relock < 0) relock = k;
    end
    check("loss1_evt_count", evts, 1);
    check("loss1_fall_edge", fall, 2);
    check("loss1_relock_gap", relock - fall, LOCK_FILT);
    check("loss1_cnt", LOSS_CNT[7:0], CNT_EN ? 32'd1 : 32'd0);

    // Forced restart out of LOCKED is not a loss.
    FORCE_RESTART = 2'b01;
    cycle("force");
    FORCE_RESTART = '0;
    width = int'(PLL_RESTART[0]); evts = int'(LOSS_EVT[0]);
    for (int k = 0; k < 6; k++) begin
      cycle("force_pulse");
      width += int'(PLL_RESTART[0]);
      evts  += int'(LOSS_EVT[0]);
    end
    check("force_width", width, RESTART_CYC);
    check("force_no_loss", evts, 0);
    check("force_cnt_kept", LOSS_CNT[7:0], CNT_EN ? 32'd1 : 32'd0);

    // Lock held low: channel 1 times out periodically.
    PLL_LOCK = '0;
    prev = int'(PLL_RESTART[1]); w = 0;
    for (int k = 0; k < 80; k++) begin
      cycle("timeout");
      if (PLL_RESTART[1] && prev == 0) begin rises.push_back(k); w = 0; end
      if (PLL_RESTART[1]) w++;
      if (!PLL_RESTART[1] && prev == 1) widths.push_back(w);
      prev = int'(PLL_RESTART[1]);
    end
    check("timeout_rises", rises.size() >= 3, 1);
    if (rises.size() >= 3 && widths.size() >= 2) begin
      check("timeout_period_a", rises[1] - rises[0], TIMEOUT_CYC + RESTART_CYC);
      check("timeout_period_b", rises[2] - rises[1], TIMEOUT_CYC + RESTART_CYC);
      check("timeout_width_a", widths[0], RESTART_CYC);
      check("timeout_width_b", widths[1], RESTART_CYC);
    end

    // 300 losses on channel 0 saturate its counter.
    PLL_LOCK[0] = 1'b1;
    for (int k = 0; k < 40 && !LOCKED[0]; k++) cycle("relock0");
    check("relock0", LOCKED[0], 1);
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 7; k++) begin
        PLL_LOCK[0] = (k != 0);
        cycle("sat");
      end
    end
    check("sat_cnt", LOSS_CNT[7:0], CNT_EN ? 32'd255 : 32'd0);

    // Clear coincident with a loss leaves exactly one.
    PLL_LOCK[0] = 1'b0;
    cycle("clr_a");
    PLL_LOCK[0] = 1'b1;
    cycle("clr_b");
    CLR_CNT = 1'b1;
    cycle("clr_c");
    CLR_CNT = 1'b0;
    check("clr_evt", LOSS_EVT[0], 1);
    check("clr_cnt_one", LOSS_CNT[7:0], CNT_EN ? 32'd1 : 32'd0);

    // Reset in the middle of a (re-forced) restart pulse.
    FORCE_RESTART = 2'b01;
    cycle("g_force");
    FORCE_RESTART = '0;
    cycle("g_pulse");
    FORCE_RESTART = 2'b01;
    cycle("g_reforce");
    FORCE_RESTART = '0;
    check("g_in_pulse", PLL_RESTART[0], 1);
    RST = 1'b1;
    #1 model_reset();
    check("g_rst_restart", PLL_RESTART, 0);
    check("g_rst_locked", LOCKED, 0);
    check("g_rst_all", ALL_LOCKED, 0);
    check("g_rst_evt", LOSS_EVT, 0);
    check("g_rst_cnt", LOSS_CNT, 0);
    cycle("g_rst_hold");
    cycle("g_rst_hold");
    RST = 1'b0;
    width = 0;
    for (int k = 0; k < 12; k++) begin
      cycle("g_after");
      width += int'(PLL_RESTART[0]);
    end
    check("g_no_resume", width, 0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N_PLL; i++)
        if ($urandom_range(23) == 0) PLL_LOCK[i] = ~PLL_LOCK[i];
      FORCE_RESTART = '0;
      for (int i = 0; i < N_PLL; i++)
        if ($urandom_range(79) == 0) FORCE_RESTART[i] = 1'b1;
      CLR_CNT = ($urandom_range(99) == 0);
      if ($urandom_range(499) == 0) begin
        RST = 1'b1;
        #1 model_reset();
        compare_all("rnd_rst_async");
        cycle("rnd_rst");
        RST = 1'b0;
      end
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
